// File: rtl/hpu_multilane.sv
// hpu_multilane: multi-lane pivot search (MAX, THRESH, THRESH_EARLY) for the LU engine.
// Define HPU_CAND_CNT_EN to add the pivot_cand_cnt candidate-count output.

module hpu_lane #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-2:0] mag_i,
  input  logic                  mask_i,
  input  logic [DATA_WIDTH-2:0] thr_i,
  output logic                  hit_o
);
  assign hit_o = mask_i && (mag_i >= thr_i);
endmodule

module hpu_multilane #(
  parameter int DATA_WIDTH = 32,
  parameter int ROW_IDX_W  = 16,
  parameter int LANES      = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        pivot_start,
  input  logic [1:0]                  search_mode,
  input  logic [DATA_WIDTH-1:0]       threshold_value,
  output logic                        pivot_busy,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [LANES*DATA_WIDTH-1:0] in_data,
  input  logic [LANES*ROW_IDX_W-1:0]  in_row_idx,
  input  logic [LANES-1:0]            in_lane_mask,
  input  logic                        is_last,
  output logic                        pivot_valid,
  input  logic                        pivot_ready,
  output logic [DATA_WIDTH-1:0]       pivot_data,
  output logic [ROW_IDX_W-1:0]        pivot_row_idx,
  output logic                        pivot_from_threshold,
  output logic                        pivot_fail
`ifdef HPU_CAND_CNT_EN
  ,
  output logic [ROW_IDX_W:0]          pivot_cand_cnt
`endif
);

  localparam logic [1:0] MODE_THR   = 2'b01;
  localparam logic [1:0] MODE_EARLY = 2'b10;
  localparam int         MW         = DATA_WIDTH - 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, OUT} state_e;

  state_e state_q, state_d;

  logic [LANES-1:0][DATA_WIDTH-1:0] lane_data;
  logic [LANES-1:0][ROW_IDX_W-1:0]  lane_idx;
  logic [LANES-1:0]                 lane_hit;

  logic [1:0]    mode_q;
  logic [MW-1:0] thr_q;
  logic          is_thr, is_early;
  logic          start_acc, beat_acc, run_acc, early_hit, decide;
  logic          unused_thr_sign;

  // Per-beat lane reduction results
  logic                  bm_vld, bh_vld;
  logic [DATA_WIDTH-1:0] bm_data, bh_data;
  logic [ROW_IDX_W-1:0]  bm_idx, bh_idx;

  logic                  s1_vld_q, s1_mvld_q, s1_hit_q;
  logic [1:0]            fin_pipe_q;
  logic [DATA_WIDTH-1:0] s1_mdata_q, s1_hdata_q;
  logic [ROW_IDX_W-1:0]  s1_midx_q, s1_hidx_q;

  logic                  acc_vld_q, hit_vld_q;
  logic [DATA_WIDTH-1:0] acc_data_q, hit_data_q;
  logic [ROW_IDX_W-1:0]  acc_idx_q, hit_idx_q;

  logic                  pv_q, pthr_q, pfail_q, pv_done_q;
  logic [DATA_WIDTH-1:0] pdata_q;
  logic [ROW_IDX_W-1:0]  pidx_q;

  assign lane_data       = in_data;
  assign lane_idx        = in_row_idx;
  assign unused_thr_sign = threshold_value[DATA_WIDTH-1];

  assign is_thr    = (mode_q == MODE_THR) || (mode_q == MODE_EARLY);
  assign is_early  = (mode_q == MODE_EARLY);
  assign in_ready  = (state_q == RUN) || (state_q == DRAIN);
  assign start_acc = (state_q == IDLE) && pivot_start;
  assign beat_acc  = in_valid && in_ready;
  assign run_acc   = beat_acc && (state_q == RUN);
  assign early_hit = run_acc && is_early && bh_vld;
  assign decide    = run_acc && (is_last || early_hit);

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    hpu_lane #(.DATA_WIDTH(DATA_WIDTH)) u_lane (
      .mag_i  (lane_data[l][MW-1:0]),
      .mask_i (in_lane_mask[l]),
      .thr_i  (thr_q),
      .hit_o  (lane_hit[l])
    );
  end

  // Lowest lane wins ties for max; lowest hitting lane is the beat's first hit.
  always_comb begin
    bm_vld  = 1'b0;
    bm_data = '0;
    bm_idx  = '0;
    bh_vld  = 1'b0;
    bh_data = '0;
    bh_idx  = '0;
    for (int l = 0; l < LANES; l++) begin
      if (in_lane_mask[l] && (!bm_vld || lane_data[l][MW-1:0] > bm_data[MW-1:0])) begin
        bm_vld  = 1'b1;
        bm_data = lane_data[l];
        bm_idx  = lane_idx[l];
      end
      if (lane_hit[l] && !bh_vld) begin
        bh_vld  = 1'b1;
        bh_data = lane_data[l];
        bh_idx  = lane_idx[l];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= 2'b00;
      thr_q  <= '0;
    end else if (start_acc) begin
      mode_q <= search_mode;
      thr_q  <= threshold_value[MW-1:0];
    end
  end

  // Stage 1: register the beat winner and its first hit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_q   <= 1'b0;
      fin_pipe_q <= '0;
      s1_mvld_q  <= 1'b0;
      s1_mdata_q <= '0;
      s1_midx_q  <= '0;
      s1_hit_q   <= 1'b0;
      s1_hdata_q <= '0;
      s1_hidx_q  <= '0;
    end else begin
      s1_vld_q   <= run_acc;
      fin_pipe_q <= {fin_pipe_q[0], decide};
      if (run_acc) begin
        s1_mvld_q  <= bm_vld;
        s1_mdata_q <= bm_data;
        s1_midx_q  <= bm_idx;
        s1_hit_q   <= bh_vld && is_thr;
        s1_hdata_q <= bh_data;
        s1_hidx_q  <= bh_idx;
      end
    end
  end

  // Stage 2: accumulate across beats; strict compare keeps the earliest beat on ties
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_vld_q  <= 1'b0;
      acc_data_q <= '0;
      acc_idx_q  <= '0;
      hit_vld_q  <= 1'b0;
      hit_data_q <= '0;
      hit_idx_q  <= '0;
    end else if (start_acc) begin
      acc_vld_q  <= 1'b0;
      acc_data_q <= '0;
      acc_idx_q  <= '0;
      hit_vld_q  <= 1'b0;
      hit_data_q <= '0;
      hit_idx_q  <= '0;
    end else if (s1_vld_q) begin
      if (s1_mvld_q && (!acc_vld_q || s1_mdata_q[MW-1:0] > acc_data_q[MW-1:0])) begin
        acc_vld_q  <= 1'b1;
        acc_data_q <= s1_mdata_q;
        acc_idx_q  <= s1_midx_q;
      end
      if (s1_hit_q && !hit_vld_q) begin
        hit_vld_q  <= 1'b1;
        hit_data_q <= s1_hdata_q;
        hit_idx_q  <= s1_hidx_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pv_q    <= 1'b0;
      pdata_q <= '0;
      pidx_q  <= '0;
      pthr_q  <= 1'b0;
      pfail_q <= 1'b0;
    end else if (fin_pipe_q[1]) begin
      pv_q <= 1'b1;
      if (hit_vld_q) begin
        pdata_q <= hit_data_q;
        pidx_q  <= hit_idx_q;
        pthr_q  <= 1'b1;
        pfail_q <= 1'b0;
      end else begin
        pdata_q <= acc_data_q;
        pidx_q  <= acc_idx_q;
        pthr_q  <= 1'b0;
        pfail_q <= is_thr || !acc_vld_q;
      end
    end else if (pv_q && pivot_ready) begin
      pv_q <= 1'b0;
    end
  end

  // Early-exit result may be consumed before the stream's last beat arrives
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                             pv_done_q <= 1'b0;
    else if (start_acc)                                     pv_done_q <= 1'b0;
    else if ((state_q == DRAIN) && pv_q && pivot_ready)     pv_done_q <= 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (pivot_start) state_d = RUN;
      RUN: begin
        if (run_acc && is_last) state_d = OUT;
        else if (early_hit)     state_d = DRAIN;
      end
      DRAIN: begin
        if (beat_acc && is_last)
          state_d = (pv_done_q || (pv_q && pivot_ready)) ? IDLE : OUT;
      end
      OUT:   if (pv_q && pivot_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

`ifdef HPU_CAND_CNT_EN
  localparam int CW = ROW_IDX_W + 1;
  localparam int PW = $clog2(LANES + 1);

  logic [CW-1:0]    cnt_q;
  logic [PW-1:0]    pop;
  logic [CW+PW-1:0] cnt_sum;

  always_comb begin
    pop = '0;
    for (int l = 0; l < LANES; l++) pop = pop + PW'(in_lane_mask[l]);
    cnt_sum = {{PW{1'b0}}, cnt_q} + (CW+PW)'(pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         cnt_q <= '0;
    else if (start_acc) cnt_q <= '0;
    else if (run_acc)   cnt_q <= (|cnt_sum[CW+PW-1:CW]) ? '1 : cnt_sum[CW-1:0];
  end

  assign pivot_cand_cnt = cnt_q;
`endif

  assign pivot_busy           = (state_q != IDLE);
  assign pivot_valid          = pv_q;
  assign pivot_data           = pdata_q;
  assign pivot_row_idx        = pidx_q;
  assign pivot_from_threshold = pthr_q;
  assign pivot_fail           = pfail_q;

endmodule

// File: tb/tb_hpu_multilane.sv
// Directed bench for hpu_multilane: expected results are queued when a stream is sent
// and popped when the pivot result appears.

module tb_hpu_multilane;
  localparam int DW = 32;
  localparam int IW = 16;
  localparam int L  = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            pivot_start = 1'b0;
  logic [1:0]      search_mode = 2'b00;
  logic [DW-1:0]   threshold_value = '0;
  logic            pivot_busy;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [L*DW-1:0] in_data = '0;
  logic [L*IW-1:0] in_row_idx = '0;
  logic [L-1:0]    in_lane_mask = '0;
  logic            is_last = 1'b0;
  logic            pivot_valid;
  logic            pivot_ready = 1'b0;
  logic [DW-1:0]   pivot_data;
  logic [IW-1:0]   pivot_row_idx;
  logic            pivot_from_threshold;
  logic            pivot_fail;
`ifdef HPU_CAND_CNT_EN
  logic [IW:0]     pivot_cand_cnt;
`endif

  always #5 clk = ~clk;

  hpu_multilane #(.DATA_WIDTH(DW), .ROW_IDX_W(IW), .LANES(L)) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .pivot_start          (pivot_start),
    .search_mode          (search_mode),
    .threshold_value      (threshold_value),
    .pivot_busy           (pivot_busy),
    .in_valid             (in_valid),
    .in_ready             (in_ready),
    .in_data              (in_data),
    .in_row_idx           (in_row_idx),
    .in_lane_mask         (in_lane_mask),
    .is_last              (is_last),
    .pivot_valid          (pivot_valid),
    .pivot_ready          (pivot_ready),
    .pivot_data           (pivot_data),
    .pivot_row_idx        (pivot_row_idx),
    .pivot_from_threshold (pivot_from_threshold),
`ifdef HPU_CAND_CNT_EN
    .pivot_cand_cnt       (pivot_cand_cnt),
`endif
    .pivot_fail           (pivot_fail)
  );

  typedef struct {
    logic [DW-1:0] data;
    logic [IW-1:0] idx;
    logic          thr;
    logic          fail;
    logic [IW:0]   cnt;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [DW-1:0] d, input logic [IW-1:0] i,
                          input logic t, input logic f, input logic [IW:0] c);
    exp_t e;
    e.data = d; e.idx = i; e.thr = t; e.fail = f; e.cnt = c;
    sb.push_back(e);
  endtask

  task automatic start(input logic [1:0] mode, input logic [DW-1:0] thr);
    search_mode = mode;
    threshold_value = thr;
    pivot_start = 1'b1;
    @(negedge clk);
    pivot_start = 1'b0;
    chk("start_busy", pivot_busy, 1'b1);
  endtask

  // Drives one beat at a negedge and returns at the negedge after it is accepted.
  task automatic beat(input logic [DW-1:0] d0, d1, d2, d3, input logic [IW-1:0] i0,
                      input logic [L-1:0] m, input logic last);
    int w;
    in_data      = {d3, d2, d1, d0};
    in_row_idx   = {i0 + IW'(3), i0 + IW'(2), i0 + IW'(1), i0};
    in_lane_mask = m;
    is_last      = last;
    in_valid     = 1'b1;
    w = 0;
    while (!in_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("beat_ready", in_ready, 1'b1);
    @(negedge clk);
  endtask

  task automatic idle();
    in_valid = 1'b0;
    is_last  = 1'b0;
  endtask

  task automatic check_result(input string tag);
    exp_t e;
    int   w;
    w = 0;
    while (!pivot_valid && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk({tag, "_valid"}, pivot_valid, 1'b1);
    if (sb.size() == 0) begin
      chk({tag, "_sb_nonempty"}, sb.size(), 1);
    end else begin
      e = sb.pop_front();
      chk({tag, "_data"}, pivot_data, e.data);
      chk({tag, "_idx"},  pivot_row_idx, e.idx);
      chk({tag, "_thr"},  pivot_from_threshold, e.thr);
      chk({tag, "_fail"}, pivot_fail, e.fail);
`ifdef HPU_CAND_CNT_EN
      chk({tag, "_cnt"},  pivot_cand_cnt, e.cnt);
`endif
    end
  endtask

  task automatic handshake();
    pivot_ready = 1'b1;
    @(negedge clk);
    pivot_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_valid", pivot_valid, 1'b0);
    chk("rst_busy",  pivot_busy, 1'b0);
    chk("rst_ready", in_ready, 1'b0);
    chk("rst_data",  pivot_data, '0);
    chk("rst_idx",   pivot_row_idx, '0);
    chk("rst_fail",  pivot_fail, 1'b0);
    chk("rst_thr",   pivot_from_threshold, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    // T1: MAX, tie between beats goes to the earlier beat; latency of 2 edges
    start(2'b00, '0);
    push_exp(32'h8000_0009, 16'd1, 1'b0, 1'b0, 17'd8);
    beat(32'd5, 32'h8000_0009, 32'd3, 32'd1, 16'd0, 4'hF, 1'b0);
    beat(32'd9, 32'd2, 32'd2, 32'd2, 16'd4, 4'hF, 1'b1);
    idle();
    chk("t1_lat0", pivot_valid, 1'b0);
    @(negedge clk);
    chk("t1_lat1", pivot_valid, 1'b0);
    @(negedge clk);
    chk("t1_lat2", pivot_valid, 1'b1);
    check_result("t1");
    handshake();
    chk("t1_idle", pivot_busy, 1'b0);

    // T2: THRESH thr=7, first hit is beat0 lane1; both beats consumed before OUT
    start(2'b01, 32'd7);
    push_exp(32'h8000_0009, 16'd1, 1'b1, 1'b0, 17'd8);
    beat(32'd5, 32'h8000_0009, 32'd3, 32'd1, 16'd0, 4'hF, 1'b0);
    chk("t2_run_ready", in_ready, 1'b1);
    beat(32'd9, 32'd2, 32'd2, 32'd2, 16'd4, 4'hF, 1'b1);
    idle();
    chk("t2_out_ready", in_ready, 1'b0);
    check_result("t2");
    handshake();
    chk("t2_idle", pivot_busy, 1'b0);

    // T3: THRESH_EARLY, hit on beat0, drain beats 1-2 with pivot_ready held low
    start(2'b10, 32'd4);
    push_exp(32'd5, 16'd0, 1'b1, 1'b0, 17'd4);
    beat(32'd5, 32'd1, 32'd1, 32'd1, 16'd0, 4'hF, 1'b0);
    chk("t3_drain_ready", in_ready, 1'b1);
    beat(32'd1, 32'd1, 32'd1, 32'd9, 16'd4, 4'hF, 1'b0);
    beat(32'd9, 32'd9, 32'd9, 32'd9, 16'd8, 4'hF, 1'b1);
    idle();
    check_result("t3");
    chk("t3_busy_wait_hs", pivot_busy, 1'b1);
    chk("t3_out_ready", in_ready, 1'b0);
    handshake();
    chk("t3_idle", pivot_busy, 1'b0);

    // T3b: THRESH_EARLY, result consumed before the last beat arrives
    start(2'b10, 32'd4);
    push_exp(32'd6, 16'd1, 1'b1, 1'b0, 17'd4);
    beat(32'd1, 32'd6, 32'd1, 32'd1, 16'd0, 4'hF, 1'b0);
    idle();
    check_result("t3b");
    handshake();
    chk("t3b_busy_wait_last", pivot_busy, 1'b1);
    chk("t3b_drain_ready", in_ready, 1'b1);
    beat(32'd0, 32'd0, 32'd0, 32'd0, 16'd4, 4'hF, 1'b1);
    idle();
    chk("t3b_idle", pivot_busy, 1'b0);

    // T4: THRESH with no hit falls back to the max winner with fail set
    start(2'b01, 32'd100);
    push_exp(32'd9, 16'd4, 1'b0, 1'b1, 17'd8);
    beat(32'd5, 32'd3, 32'd2, 32'd1, 16'd0, 4'hF, 1'b0);
    beat(32'd9, 32'd2, 32'd2, 32'd9, 16'd4, 4'hF, 1'b1);
    idle();
    check_result("t4");
    handshake();

    // T5: every lane masked off
    start(2'b00, '0);
    push_exp('0, '0, 1'b0, 1'b1, 17'd0);
    beat(32'd7, 32'd7, 32'd7, 32'd7, 16'd3, 4'h0, 1'b1);
    idle();
    check_result("t5");
    handshake();

    // T6: async reset mid-stream aborts the search
    start(2'b00, '0);
    beat(32'd5, 32'd5, 32'd5, 32'd5, 16'd0, 4'hF, 1'b0);
    idle();
    #1 rst_n = 1'b0;
    #1;
    chk("t6_rst_busy",  pivot_busy, 1'b0);
    chk("t6_rst_ready", in_ready, 1'b0);
    chk("t6_rst_valid", pivot_valid, 1'b0);
    chk("t6_rst_fail",  pivot_fail, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("t6_no_result", pivot_valid, 1'b0);

    // T6b: pivot_start in OUT ignored, stalled outputs held
    start(2'b00, '0);
    push_exp(32'h8000_0009, 16'd1, 1'b0, 1'b0, 17'd8);
    beat(32'd5, 32'h8000_0009, 32'd3, 32'd1, 16'd0, 4'hF, 1'b0);
    beat(32'd9, 32'd2, 32'd2, 32'd2, 16'd4, 4'hF, 1'b1);
    idle();
    check_result("t6b");
    pivot_start = 1'b1;
    search_mode = 2'b01;
    threshold_value = 32'd1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("t6b_hold_valid", pivot_valid, 1'b1);
      chk("t6b_hold_data",  pivot_data, 32'h8000_0009);
      chk("t6b_hold_idx",   pivot_row_idx, 16'd1);
      chk("t6b_hold_ready", in_ready, 1'b0);
    end
    pivot_start = 1'b0;
    handshake();
    chk("t6b_idle", pivot_busy, 1'b0);
    chk("t6b_valid_drop", pivot_valid, 1'b0);
    chk("sb_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
